// File: rtl/uart_fifo_if.sv
// Register-window bus for uart_fifo: one access per valid strobe, wr selects direction.
interface uart_fifo_if;
  logic        addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        wr;
  logic        valid;

  modport master (output addr, din, wr, valid, input dout);
  modport slave  (input addr, din, wr, valid, output dout);
endinterface

// File: rtl/uart_fifo.sv
// Buffered 8N1 UART: TX FIFO + shifter, optional RX path, DATA/STATUS register window.
// Define UART_RX_EN to build the receiver and RX FIFO; without it the block is TX-only.
module uart_fifo #(
  parameter int unsigned CLK_DIV  = 434,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_fifo_if.slave bus,
  input  logic       rxd,
  output logic       txd
);
  localparam int unsigned   CW       = $clog2(CLK_DIV);
  localparam int unsigned   TXAW     = $clog2(TX_DEPTH);
  localparam int unsigned   TXPW     = TXAW + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;

  logic data_wr, data_rd, stat_rd;
  assign data_wr = bus.valid &  bus.wr & ~bus.addr;
  assign data_rd = bus.valid & ~bus.wr & ~bus.addr;
  assign stat_rd = bus.valid & ~bus.wr &  bus.addr;

  logic unused_din;
  assign unused_din = ^bus.din[31:8];

  // TX FIFO
  logic [7:0]      tx_mem_q [TX_DEPTH];
  logic [TXPW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic            tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]      tx_head;

  assign tx_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
  assign tx_full  = (tx_wr_ptr_q[TXAW] != tx_rd_ptr_q[TXAW]) &&
                    (tx_wr_ptr_q[TXAW-1:0] == tx_rd_ptr_q[TXAW-1:0]);
  assign tx_push  = data_wr & (~tx_full | tx_pop);
  assign tx_head  = tx_mem_q[tx_rd_ptr_q[TXAW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q[TXAW-1:0]] <= bus.din[7:0];
  end

  // TX shifter: frame is {stop, data, start}, txd is the register LSB
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_shift_q, tx_shift_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: tx_pop = ~tx_empty;
      TX_SHIFT: begin
        if (tx_cnt_q != BIT_END) begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end else if (tx_bit_q != 4'd9) begin
          tx_cnt_d   = '0;
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
        end else if (tx_empty) begin
          tx_cnt_d   = '0;
          tx_shift_d = '1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_pop = 1'b1;
        end
      end
    endcase
    // Loading straight from the stop bit keeps back-to-back frames gapless
    if (tx_pop) begin
      tx_state_d = TX_SHIFT;
      tx_shift_d = {1'b1, tx_head, 1'b0};
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
    end
  end

  assign txd = tx_shift_q[0];

  logic       ovr, ferr, rx_avail;
  logic [7:0] rx_head;
  logic       tx_idle;
  logic [31:0] status, dout_q, dout_d;

  assign tx_idle = tx_empty & (tx_state_q == TX_IDLE);
  assign status  = {17'h0, tx_idle, ~tx_full, 10'h0, ferr, ovr, rx_avail};

  always_comb begin
    dout_d = dout_q;
    if (stat_rd)      dout_d = status;
    else if (data_rd) dout_d = rx_avail ? {24'h0, rx_head} : 32'h0;
  end

  assign bus.dout = dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '1;
      dout_q      <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TXPW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TXPW'(1);
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      dout_q     <= dout_d;
    end
  end

`ifdef UART_RX_EN
  localparam int unsigned RXAW = $clog2(RX_DEPTH);
  localparam int unsigned RXPW = RXAW + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_done, rx_ferr;
  logic [7:0]      rx_mem_q [RX_DEPTH];
  logic [RXPW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic            rx_empty, rx_full, rx_push, rx_pop;
  logic            ovr_q, ferr_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q & ~rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q != HALF_END) begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end else begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != BIT_END) begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end else begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q != BIT_END) begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end else begin
          rx_cnt_d   = '0;
          rx_done    = rx_s2_q;
          rx_ferr    = ~rx_s2_q;
          rx_state_d = RX_IDLE;
        end
      end
    endcase
  end

  assign rx_empty = (rx_wr_ptr_q == rx_rd_ptr_q);
  assign rx_full  = (rx_wr_ptr_q[RXAW] != rx_rd_ptr_q[RXAW]) &&
                    (rx_wr_ptr_q[RXAW-1:0] == rx_rd_ptr_q[RXAW-1:0]);
  assign rx_pop   = data_rd & ~rx_empty;
  // A concurrent CPU pop frees the slot, so a push into a full FIFO still lands
  assign rx_push  = rx_done & (~rx_full | rx_pop);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q[RXAW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RXPW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RXPW'(1);
      // New events win over a coincident clear-on-read
      ovr_q  <= (ovr_q & ~stat_rd) | (rx_done & rx_full & ~rx_pop);
      ferr_q <= (ferr_q & ~stat_rd) | rx_ferr;
    end
  end

  assign ovr      = ovr_q;
  assign ferr     = ferr_q;
  assign rx_avail = ~rx_empty;
  assign rx_head  = rx_mem_q[rx_rd_ptr_q[RXAW-1:0]];
`else
  logic unused_rx;
  assign unused_rx = rxd;
  assign ovr       = 1'b0;
  assign ferr      = 1'b0;
  assign rx_avail  = 1'b0;
  assign rx_head   = 8'h0;
`endif
endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised buffered UART for the RISC-V SoC peripheral bus: a full-duplex 8N1 transmitter and receiver behind one 32-bit register window. TX and RX FIFOs decouple the CPU from the line rate. The status word keeps bits 13/14 compatible with existing polling firmware (0x6000 = ready). Sits on the same valid/wr strobe bus as the other I/O blocks.

## Interface
- CLK_DIV, 434: clocks per bit; ≥ 4.
- TX_DEPTH, 16: TX FIFO entries; power of 2, ≥ 2.
- RX_DEPTH, 16: RX FIFO entries; power of 2, ≥ 2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  1  register select: 0 = DATA, 1 = STATUS.
- din  in  32  write data; only [7:0] is used for DATA writes.
- dout  out  32  registered read data.
- wr  in  1  1 = write, 0 = read; qualified by valid.
- valid  in  1  access strobe, one cycle per access.
- rxd  in  1  serial input, asynchronous to clk.
- txd  out  1  serial output, idle high.

## Operation
- DATA write (valid & wr & addr=0): pushes din[7:0] into TX FIFO. If the FIFO is full, the byte is dropped silently.
- DATA read (valid & !wr & addr=0): dout = {24'h0, head byte}, then pops. If RX FIFO is empty: dout = 0, no pop.
- STATUS read: dout = {17'h0, tx_idle[14], tx_not_full[13], 10'h0, ferr[2], ovr[1], rx_avail[0]}.
  - tx_idle = TX FIFO empty and shifter idle.
  - ovr and ferr are sticky. Both clear on a STATUS read, and the read returns their pre-clear values.
- Writes to STATUS are ignored.
- TX FSM:
  - TX_IDLE: txd=1. When the FIFO is non-empty, pop and load {1, byte, 0} into the shifter, then go to TX_SHIFT.
  - TX_SHIFT: shifts LSB-first, one bit per CLK_DIV cycles. After the stop bit, return to TX_IDLE.
  - Back-to-back bytes have no idle gap.
- RX path: rxd passes through a 2-flop synchronizer (reset value 1). RX FSM:
  - RX_IDLE: on a falling edge, go to RX_START.
  - RX_START: at CLK_DIV/2 cycles, sample. If high, treat as a glitch and return to RX_IDLE. Otherwise go to RX_DATA.
  - RX_DATA: 8 samples at CLK_DIV intervals, LSB-first.
  - RX_STOP: sample once. If low, set ferr and discard the byte. If high, push the byte. If the FIFO is full, set ovr and drop the new byte (old data is kept). Return to RX_IDLE immediately after the stop sample.
- Simultaneous RX push and CPU pop in the same cycle: both take effect and the count is unchanged. A push into a full FIFO that coincides with a pop succeeds.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and the rest are equal.
- Bit counter width is $clog2(CLK_DIV). It resets to 0 on every FSM state entry.

## Timing
- Reset values: txd=1, dout=0, FIFOs empty, ovr=ferr=0, both FSMs idle, synchronizer = 1.
- Reset asserted mid-frame: txd goes to 1 asynchronously and all contents are lost.
- Read latency: dout is valid on the cycle after the valid strobe. It holds until the next read and does not change on writes.
- STATUS after a DATA write to an idle UART: tx_idle reads 0 from the following cycle on.
- TX: txd goes low (start bit) 2 cycles after the write strobe when idle. Each bit lasts exactly CLK_DIV cycles, so a frame is 10·CLK_DIV cycles.
- RX: rx_avail rises within 4 cycles of the stop-bit sample point. Each sample point is (CLK_DIV/2 + n·CLK_DIV) cycles after the synchronized falling edge.

## Configuration
- UART_RX_EN defined: the full RX path and RX FIFO are built.
- UART_RX_EN undefined:
  - No RX logic; rxd is unused.
  - STATUS bits [2:0] read 0 and DATA reads return 0.
  - TX behaviour is identical in both builds.

## Test plan
- Bench uses CLK_DIV=8, TX_DEPTH=RX_DEPTH=4.
- Reset, then STATUS read -> dout=0x6000 and txd=1.
- Write 0xA5 -> txd low 2 cycles later. Line is 0,1,0,1,0,0,1,0,1,1, 8 cycles each. tx_idle=1 after 80 cycles.
- Write 6 bytes back-to-back:
  - First 5 accepted (4 in FIFO + 1 popped into the shifter after 2 cycles), 6th dropped. tx_not_full=0 during the burst.
  - 5 contiguous frames, no gaps.
- Drive 0x3C on rxd at 8 cycles/bit -> rx_avail=1. DATA read returns 0x3C, then rx_avail=0.
- Send 5 RX frames without reading:
  - STATUS = 0x6003; the second read returns 0x6001.
  - DATA reads return the first 4 bytes in order.
- Frame with stop bit 0 -> ferr=1 and nothing pushed. A 3-cycle low glitch on rxd -> no byte, no flags.
